// File: rtl/bcd_div_seq_pkg.sv
// Shared types and constants for the sequential BCD divider.
package bcd_div_seq_pkg;

  // Controller states
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    SUB,
    DONE
  } state_e;

  // Width of one BCD digit
  localparam int DIGIT_W = 4;

  // Restoring-subtract cycles spent on every quotient digit
  localparam int SUB_CYCLES = 9;

endpackage

// File: rtl/bcd_div_seq_sub_cmp.sv
// Combinational multi-digit BCD subtract-with-borrow. The final borrow
// doubles as the magnitude compare: no borrow means a_i >= b_i.
module bcd_sub_cmp
  import bcd_div_seq_pkg::*;
#(
  parameter int N_DIGITS = 5
) (
  input  logic [DIGIT_W*N_DIGITS-1:0] a_i,
  input  logic [DIGIT_W*N_DIGITS-1:0] b_i,
  output logic [DIGIT_W*N_DIGITS-1:0] diff_o,
  output logic                        ge_o
);

  // Ripple the borrow from the least significant digit upward
  always_comb begin
    logic       borrow;
    logic [4:0] t;
    borrow = 1'b0;
    t      = '0;
    diff_o = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      t = {1'b0, a_i[i*DIGIT_W +: DIGIT_W]} - {1'b0, b_i[i*DIGIT_W +: DIGIT_W]}
          - {4'b0000, borrow};
      if (t[4]) begin
        // Negative digit: wrap by adding ten, carry the borrow on
        diff_o[i*DIGIT_W +: DIGIT_W] = t[3:0] + 4'd10;
        borrow = 1'b1;
      end else begin
        diff_o[i*DIGIT_W +: DIGIT_W] = t[3:0];
        borrow = 1'b0;
      end
    end
    ge_o = ~borrow;
  end

endmodule

// File: rtl/bcd_div_seq.sv
// Sequential BCD long divider: one quotient digit per SHIFT + 9 SUB cycles,
// with operand validation (bad nibble, zero divisor) done up front in LOAD.
module bcd_div_seq
  import bcd_div_seq_pkg::*;
#(
  parameter int N_DIGITS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [DIGIT_W*N_DIGITS-1:0] dig1,
  input  logic [DIGIT_W*N_DIGITS-1:0] dig2,
  output logic                        busy,
  output logic                        done,
  output logic [DIGIT_W*N_DIGITS-1:0] res,
  output logic [DIGIT_W*N_DIGITS-1:0] rem,
  output logic                        div_zero,
  output logic                        bad_digit
);

  localparam int W     = DIGIT_W * N_DIGITS;
  localparam int WR    = W + DIGIT_W;           // partial remainder has one spare digit
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  state_e               state_q, state_d;
  logic [W-1:0]         a_q, a_d;
  logic [W-1:0]         b_q, b_d;
  logic [WR-1:0]        prem_q, prem_d;
  logic [W-1:0]         quo_q, quo_d;
  logic [DIGIT_W-1:0]   qdig_q, qdig_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 dz_q, dz_d;
  logic                 bd_q, bd_d;
  logic                 done_q;

  logic [WR-1:0]        diff;
  logic                 ge;
  logic [W-1:0]         a_sh;
  logic [DIGIT_W-1:0]   cur_dig;
  logic [DIGIT_W-1:0]   qdig_nxt;

  // True when any nibble of the operand is outside 0..9
  function automatic logic has_bad(input logic [W-1:0] v);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_DIGITS; i++)
      if (v[i*DIGIT_W +: DIGIT_W] > 4'd9) r = 1'b1;
    return r;
  endfunction

  bcd_sub_cmp #(
    .N_DIGITS(N_DIGITS + 1)
  ) u_sub (
    .a_i   (prem_q),
    .b_i   ({{DIGIT_W{1'b0}}, b_q}),
    .diff_o(diff),
    .ge_o  (ge)
  );

  assign a_sh     = a_q >> {idx_q, 2'b00};
  assign cur_dig  = a_sh[DIGIT_W-1:0];
  assign qdig_nxt = ge ? qdig_q + 4'd1 : qdig_q;

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    prem_d  = prem_q;
    quo_d   = quo_q;
    qdig_d  = qdig_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    bd_d    = bd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = dig1;
          b_d     = dig2;
          state_d = LOAD;
        end
      end
      LOAD: begin
        prem_d = '0;
        quo_d  = '0;
        dz_d   = 1'b0;
        bd_d   = 1'b0;
        idx_d  = IDX_W'(N_DIGITS - 1);
        if (has_bad(a_q) || has_bad(b_q)) begin
          bd_d    = 1'b1;
          state_d = DONE;
        end else if (b_q == '0) begin
          dz_d    = 1'b1;
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        prem_d  = {prem_q[W-1:0], cur_dig};
        qdig_d  = '0;
        cnt_d   = '0;
        state_d = SUB;
      end
      SUB: begin
        if (ge) prem_d = diff;
        qdig_d = qdig_nxt;
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'(SUB_CYCLES - 1)) begin
          // Quotient register was cleared in LOAD, so OR-ing in the digit is exact
          quo_d = quo_q | (W'(qdig_nxt) << {idx_q, 2'b00});
          if (idx_q == '0) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q - IDX_W'(1);
            state_d = SHIFT;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; done is a registered pulse following DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      prem_q  <= '0;
      quo_q   <= '0;
      qdig_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      bd_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prem_q  <= prem_d;
      quo_q   <= quo_d;
      qdig_q  <= qdig_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      bd_q    <= bd_d;
      done_q  <= (state_q == DONE);
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign res       = quo_q;
  assign rem       = prem_q[W-1:0];
  assign div_zero  = dz_q;
  assign bad_digit = bd_q;

endmodule

// File: tb/tb_bcd_div_seq.sv
// Scoreboard bench for bcd_div_seq, exercising a 4-digit and a 1-digit instance.
module tb_bcd_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start4, start1;
  logic [15:0] d1_4, d2_4, res4, rem4;
  logic [3:0]  d1_1, d2_1, res1, rem1;
  logic        busy4, done4, dz4, bd4;
  logic        busy1, done1, dz1, bd1;

  int total = 0;
  int bad   = 0;
  bit use1  = 1'b0;

  typedef struct {
    logic [15:0] res;
    logic [15:0] rem;
    logic        dz;
    logic        bd;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  bcd_div_seq #(.N_DIGITS(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .dig1(d1_4), .dig2(d2_4),
    .busy(busy4), .done(done4), .res(res4), .rem(rem4),
    .div_zero(dz4), .bad_digit(bd4)
  );

  bcd_div_seq #(.N_DIGITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .dig1(d1_1), .dig2(d2_1),
    .busy(busy1), .done(done1), .res(res1), .rem(rem1),
    .div_zero(dz1), .bad_digit(bd1)
  );

  logic [15:0] o_res, o_rem;
  logic        o_busy, o_done, o_dz, o_bd;
  assign o_res  = use1 ? {12'h000, res1} : res4;
  assign o_rem  = use1 ? {12'h000, rem1} : rem4;
  assign o_busy = use1 ? busy1 : busy4;
  assign o_done = use1 ? done1 : done4;
  assign o_dz   = use1 ? dz1 : dz4;
  assign o_bd   = use1 ? bd1 : bd4;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int bcd2bin(input int n, input logic [15:0] v);
    int r;
    logic [15:0] t;
    r = 0;
    t = v;
    for (int i = n - 1; i >= 0; i--) r = r * 10 + int'((t >> (4 * i)) & 16'hF);
    return r;
  endfunction

  function automatic logic [15:0] bin2bcd(input int v);
    logic [15:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r = r | (16'(t % 10) << (4 * i));
      t = t / 10;
    end
    return r;
  endfunction

  function automatic exp_t model(input int n, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    logic badn;
    int av, bv;
    badn = 1'b0;
    for (int i = 0; i < n; i++)
      if (((a >> (4 * i)) & 16'hF) > 9 || ((b >> (4 * i)) & 16'hF) > 9) badn = 1'b1;
    e.res = '0; e.rem = '0; e.dz = 1'b0; e.bd = 1'b0; e.lat = 2;
    av = bcd2bin(n, a);
    bv = bcd2bin(n, b);
    if (badn) e.bd = 1'b1;
    else if (bv == 0) e.dz = 1'b1;
    else begin
      e.res = bin2bcd(av / bv);
      e.rem = bin2bcd(av % bv);
      e.lat = 10 * n + 2;
    end
    return e;
  endfunction

  task automatic set_start(input bit v);
    if (use1) start1 = v; else start4 = v;
  endtask

  // One transaction: drive, push expectation, wait for done, pop and compare.
  // With poke set, extra start pulses land mid-operation and in the DONE cycle.
  task automatic run_op(input bit one, input logic [15:0] a, input logic [15:0] b, input bit poke);
    exp_t e, g;
    int   cnt;
    bit   seen;
    use1 = one;
    @(negedge clk);
    if (one) begin d1_1 = a[3:0]; d2_1 = b[3:0]; end
    else begin d1_4 = a; d2_4 = b; end
    set_start(1'b1);
    e = model(one ? 1 : 4, a, b);
    sb.push_back(e);
    @(posedge clk);
    #1;
    set_start(1'b0);
    d1_4 = 16'($urandom); d2_4 = 16'($urandom);
    d1_1 = 4'($urandom);  d2_1 = 4'($urandom);
    chk("busy_after_start", o_busy, 1'b1);
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < 200) begin
      @(posedge clk);
      cnt++;
      #1;
      set_start(1'b0);
      if (o_done) seen = 1'b1;
      else if (poke && (cnt == 5 || cnt == e.lat - 1)) set_start(1'b1);
    end
    set_start(1'b0);
    g = sb.pop_front();
    if (!seen) chk("done_timeout", 0, 1);
    else begin
      chk("latency", cnt, g.lat);
      chk("busy_at_done", o_busy, 1'b0);
      chk("res", o_res, g.res);
      chk("rem", o_rem, g.rem);
      chk("div_zero", o_dz, g.dz);
      chk("bad_digit", o_bd, g.bd);
    end
    @(posedge clk);
    #1;
    chk("done_pulse_width", o_done, 1'b0);
    chk("no_queued_op", o_busy, 1'b0);
    chk("res_hold", o_res, g.res);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, {busy4, busy1}, 2'b00);
    chk({tag, "_done"}, {done4, done1}, 2'b00);
    chk({tag, "_res"}, {res4, res1}, 20'h0);
    chk({tag, "_rem"}, {rem4, rem1}, 20'h0);
    chk({tag, "_flags"}, {dz4, bd4, dz1, bd1}, 4'h0);
  endtask

  initial begin
    rst = 1'b1;
    start4 = 1'b0; start1 = 1'b0;
    d1_4 = '0; d2_4 = '0; d1_1 = '0; d2_1 = '0;
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    run_op(0, 16'h9876, 16'h0012, 0);
    run_op(0, 16'h1000, 16'h0007, 0);
    run_op(1, 16'h0009, 16'h0002, 0);
    run_op(1, 16'h0008, 16'h0009, 0);
    run_op(0, 16'h0005, 16'h0000, 0);
    run_op(0, 16'h0009, 16'h0003, 0);
    run_op(0, 16'h1A00, 16'h0003, 0);
    run_op(0, 16'h1A00, 16'h0000, 0);
    run_op(0, 16'h0012, 16'h00B1, 0);
    run_op(0, 16'h0000, 16'h0005, 0);
    run_op(0, 16'h0012, 16'h0345, 0);
    run_op(0, 16'h9999, 16'h0001, 1);
    run_op(1, 16'h0000, 16'h0000, 1);
    run_op(1, 16'h000F, 16'h0003, 0);

    // Reset in the middle of 9999 / 0003
    use1 = 1'b0;
    @(negedge clk);
    d1_4 = 16'h9999; d2_4 = 16'h0003; start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk_zero("midop_reset");
    @(negedge clk);
    rst = 1'b0;
    run_op(0, 16'h0100, 16'h0004, 1);

    for (int k = 0; k < 6; k++) begin
      run_op(0, bin2bcd($urandom_range(0, 9999)), bin2bcd($urandom_range(1, 9999)), k[0]);
      run_op(1, bin2bcd($urandom_range(0, 9)), bin2bcd($urandom_range(0, 9)), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
